hyperbus_target: RTL and testbench
==================================

Name: hyperbus_target

Overview:
- Synthesizable HyperBus responder (HyperRAM-like device) with an internal word memory.
- Sits on the same ram_cs/ram_clk/ram_adq/ram_rwds bus that the system's HyperBus initiator drives, so FPGA builds and bus-level regressions run against our own RTL instead of the vendor model.
- Oversamples the bus with the local clock; ram_clk is treated as data, not as a clock.

Parameters:
- AW, 10: memory address width in 16-bit words; depth = 2^AW.
- LATENCY, 6: initial latency in ram_clk cycles; always applied doubled (fixed 2x latency).
- WRAP_LEN, 16: words per wrapped-burst group; power of two.
- ID0, 16'h0C81: value returned for register-space reads at word address 0.

Ports:
- clk  input  1  local sampling clock; must be ≥4x ram_clk.
- rst  input  1  asynchronous active-high reset.
- ram_cs  input  1  bus chip select, active low.
- ram_clk  input  1  bus clock from initiator, sampled.
- ram_adq  inout  8  DDR address/command/data.
- ram_rwds  inout  1  latency indicator (CA phase), read strobe, write mask.
- busy  output  1  high from CS-low detected until return to IDLE.
- err  output  1  one-clk pulse when CS rises during CMD or LAT.

Behaviour:
Reset:
- ram_adq and ram_rwds high-Z; busy=0; err=0; cr0=16'h8F1F; state IDLE.
- Memory contents are not reset.

Sampling:
- ram_cs, ram_clk, ram_adq and ram_rwds pass together through a 2-flop pipeline.
- A bus edge is an inequality of the two ram_clk stages. Data is taken from the same stage, so the skew of all inputs is identical.

States: IDLE, CMD, LAT, WRITE, READ, DONE.
- IDLE -> CMD when sampled ram_cs=0; busy=1.
- CMD:
  - Drive ram_rwds=1 (2x latency) from CMD entry until LAT exit.
  - Shift 6 bytes MSB first, one per bus edge, into ca[47:0].
  - ca[47]=read, ca[46]=register space, ca[45]=linear burst.
  - Word address = {ca[44:16], ca[2:0]}, truncated to AW.
  - After the 6th byte:
    - Register write -> WRITE, zero latency.
    - Otherwise -> LAT, counter = 4*LATENCY edges.
- LAT: count down on bus edges. At 0 -> READ or WRITE.
- WRITE:
  - Byte pairs: first edge = bits [15:8], second edge = bits [7:0]. ram_rwds sampled per byte; 1 = masked.
  - Commit the word on the second byte, then advance the address.
  - Register space: any address writes cr0; ID0 is read-only.
  - A half word left when CS rises is discarded.
- READ:
  - First drive of ram_adq/ram_rwds starts 1 clk after LAT exits.
  - On each bus edge, drive the next byte (upper then lower) and toggle ram_rwds. ram_rwds starts 0 and is driven high on the first byte.
  - Register space: address 0 -> ID0, else cr0.
- Addressing:
  - Linear: address+1, wraps at 2^AW.
  - Wrapped: low log2(WRAP_LEN) bits increment modulo WRAP_LEN; upper bits fixed.
  - Register space never auto-increments.
- CS high:
  - Sampled ram_cs=1 in any non-IDLE state -> next clk: all outputs high-Z, state IDLE, busy=0.
  - CS high in CMD or LAT also pulses err.
  - DONE is unused except as a hold state. If a bus edge arrives with CS low after an error, stay in DONE until CS high.
- Simultaneous events: CS rise and a bus edge in the same sample: CS wins and the edge is ignored.
- Async rst mid-transfer: immediate high-Z; memory keeps already-committed words.
- Memory and cr0 are written only on committed words; reads are combinational from the array index.

Optional Feature:
HBT_BYTE_MASK_EN
- Defined: ram_rwds=1 during a WRITE byte keeps the old memory byte (read-modify-write on the word).
- Undefined: ram_rwds ignored in WRITE; both bytes always written. Applies to register writes as well.

Test Plan:
- Linear write 4 words (0x1111,0x2222,0x3333,0x4444) at word 0x10, then linear read at 0x10 -> same 4 words in order; ram_rwds toggles 8 times; first data arrives after 12 ram_clk latency.
- Wrapped read of 4 words starting at word 0x1E (WRAP_LEN=16) -> words 0x1E,0x1F,0x10,0x11.
- Register read address 0 -> 0x0C81. Register write 0x8F17, zero latency; then register read address 1 -> 0x8F17.
- With HBT_BYTE_MASK_EN: write 0xABCD over 0x1234, low byte masked -> read 0xAB34. Without the macro -> 0xABCD.
- CS raised after 3 CA bytes -> err pulses once; buses high-Z on the next clk; busy=0; the following full transaction works.
- rst asserted mid-READ -> ram_adq/ram_rwds high-Z immediately; words written earlier still read back correctly after release.

Source files
------------

// File: rtl/hyperbus_if.sv
// HyperBus pin bundle: initiator and responder drive separate pads; the shared bus
// value is resolved here, and the responder's drive wins while its enable is high.
interface hyperbus_if;
  logic       ram_cs;
  logic       ram_clk;
  logic [7:0] ram_adq_m;
  logic       ram_rwds_m;
  logic [7:0] ram_adq_s;
  logic       ram_adq_s_oe;
  logic       ram_rwds_s;
  logic       ram_rwds_s_oe;
  logic [7:0] ram_adq;
  logic       ram_rwds;
  logic       busy;
  logic       err;

  assign ram_adq  = ram_adq_s_oe  ? ram_adq_s  : ram_adq_m;
  assign ram_rwds = ram_rwds_s_oe ? ram_rwds_s : ram_rwds_m;

  modport master (
    output ram_cs, ram_clk, ram_adq_m, ram_rwds_m,
    input  ram_adq, ram_rwds, ram_adq_s_oe, ram_rwds_s_oe, busy, err
  );

  modport slave (
    input  ram_cs, ram_clk, ram_adq, ram_rwds,
    output ram_adq_s, ram_adq_s_oe, ram_rwds_s, ram_rwds_s_oe, busy, err
  );
endinterface

// File: rtl/hyperbus_target.sv
// HyperRAM-style responder with an internal word memory; the bus is oversampled on clk.
// Optional HBT_BYTE_MASK_EN: honour ram_rwds as a per-byte write mask (read-modify-write).
module hyperbus_target #(
  parameter int unsigned AW       = 10,
  parameter int unsigned LATENCY  = 6,
  parameter int unsigned WRAP_LEN = 16,
  parameter logic [15:0] ID0      = 16'h0C81
) (
  input logic       clk,
  input logic       rst,
  hyperbus_if.slave bus
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned WB    = $clog2(WRAP_LEN);
  localparam int unsigned LW    = $clog2(4 * LATENCY + 1);
  localparam logic [LW-1:0] LAT_EDGES = LW'(4 * LATENCY);

  typedef enum logic [2:0] {IDLE, CMD, LAT, WRITE, READ, DONE} state_e;

  state_e        state_q;
  logic          cs_s1_q, cs_s2_q, ck_s1_q, ck_s2_q, rwds_s1_q, rwds_s2_q;
  logic [7:0]    adq_s1_q, adq_s2_q;
  logic [39:0]   ca_q;
  logic [2:0]    nbyte_q;
  logic [LW-1:0] lat_q;
  logic          rd_q, reg_q, lin_q;
  logic [AW-1:0] addr_q;
  logic          hi_done_q;
  logic [7:0]    wbuf_q;
  logic          wmask_hi_q;
  logic [15:0]   cr0_q;
  logic [7:0]    adq_q;
  logic          adq_oe_q, rwds_q, rwds_oe_q, busy_q, err_q;
  logic [15:0]   mem_q [DEPTH];

  logic          edge_c;
  logic [47:0]   ca_c;
  logic [AW-1:0] ca_addr_c;
  logic [15:0]   rd_word_c;
  logic [15:0]   wr_word_c;
  logic          wr_commit_c;
  logic          unused_c;

  assign edge_c      = ck_s1_q ^ ck_s2_q;
  assign ca_c        = {ca_q, adq_s2_q};
  assign ca_addr_c   = AW'({ca_c[44:16], ca_c[2:0]});
  assign rd_word_c   = reg_q ? ((addr_q == '0) ? ID0 : cr0_q) : mem_q[addr_q];
  assign wr_commit_c = (state_q == WRITE) && !cs_s2_q && edge_c && hi_done_q;

`ifdef HBT_BYTE_MASK_EN
  logic [15:0] old_word_c;
  assign old_word_c = reg_q ? cr0_q : mem_q[addr_q];
  assign wr_word_c  = {wmask_hi_q ? old_word_c[15:8] : wbuf_q,
                       rwds_s2_q  ? old_word_c[7:0]  : adq_s2_q};
  assign unused_c   = ^ca_c[15:3];
`else
  assign wr_word_c  = {wbuf_q, adq_s2_q};
  assign unused_c   = ^{ca_c[15:3], wmask_hi_q};
`endif

  assign bus.ram_adq_s     = adq_q;
  assign bus.ram_adq_s_oe  = adq_oe_q;
  assign bus.ram_rwds_s    = rwds_q;
  assign bus.ram_rwds_s_oe = rwds_oe_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;

  // Register space holds its address; wrapped bursts only roll the low WB bits.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic is_reg,
                                              input logic is_lin);
    if (is_reg) return a;
    if (is_lin) return a + AW'(1);
    return {a[AW-1:WB], a[WB-1:0] + WB'(1)};
  endfunction

  always_ff @(posedge clk) begin
    if (wr_commit_c && !reg_q) mem_q[addr_q] <= wr_word_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      ck_s1_q    <= 1'b0;
      ck_s2_q    <= 1'b0;
      rwds_s1_q  <= 1'b0;
      rwds_s2_q  <= 1'b0;
      adq_s1_q   <= '0;
      adq_s2_q   <= '0;
      ca_q       <= '0;
      nbyte_q    <= '0;
      lat_q      <= '0;
      rd_q       <= 1'b0;
      reg_q      <= 1'b0;
      lin_q      <= 1'b0;
      addr_q     <= '0;
      hi_done_q  <= 1'b0;
      wbuf_q     <= '0;
      wmask_hi_q <= 1'b0;
      cr0_q      <= 16'h8F1F;
      adq_q      <= '0;
      adq_oe_q   <= 1'b0;
      rwds_q     <= 1'b0;
      rwds_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cs_s1_q   <= bus.ram_cs;
      ck_s1_q   <= bus.ram_clk;
      adq_s1_q  <= bus.ram_adq;
      rwds_s1_q <= bus.ram_rwds;
      cs_s2_q   <= cs_s1_q;
      ck_s2_q   <= ck_s1_q;
      adq_s2_q  <= adq_s1_q;
      rwds_s2_q <= rwds_s1_q;
      err_q     <= 1'b0;
      // CS high beats any bus edge seen in the same sample.
      if (state_q != IDLE && cs_s2_q) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        adq_oe_q  <= 1'b0;
        rwds_oe_q <= 1'b0;
        err_q     <= (state_q == CMD) || (state_q == LAT);
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!cs_s2_q) begin
              busy_q <= 1'b1;
              // An edge already in flight at CS fall means framing is lost: sit out the burst.
              if (edge_c) begin
                state_q <= DONE;
              end else begin
                state_q   <= CMD;
                rwds_oe_q <= 1'b1;
                rwds_q    <= 1'b1;
                nbyte_q   <= '0;
              end
            end
          end
          CMD: begin
            if (edge_c) begin
              ca_q    <= ca_c[39:0];
              nbyte_q <= nbyte_q + 3'd1;
              if (nbyte_q == 3'd5) begin
                rd_q      <= ca_c[47];
                reg_q     <= ca_c[46];
                lin_q     <= ca_c[45];
                addr_q    <= ca_addr_c;
                hi_done_q <= 1'b0;
                lat_q     <= LAT_EDGES;
                if (!ca_c[47] && ca_c[46]) begin
                  state_q   <= WRITE;
                  rwds_oe_q <= 1'b0;
                end else begin
                  state_q <= LAT;
                end
              end
            end
          end
          LAT: begin
            if (lat_q == '0) begin
              state_q   <= rd_q ? READ : WRITE;
              rwds_oe_q <= 1'b0;
              rwds_q    <= 1'b0;
            end else if (edge_c) begin
              lat_q <= lat_q - LW'(1);
            end
          end
          WRITE: begin
            if (edge_c) begin
              if (!hi_done_q) begin
                wbuf_q     <= adq_s2_q;
                wmask_hi_q <= rwds_s2_q;
                hi_done_q  <= 1'b1;
              end else begin
                if (reg_q) cr0_q <= wr_word_c;
                addr_q    <= next_addr(addr_q, reg_q, lin_q);
                hi_done_q <= 1'b0;
              end
            end
          end
          READ: begin
            if (edge_c) begin
              adq_oe_q  <= 1'b1;
              rwds_oe_q <= 1'b1;
              rwds_q    <= ~rwds_q;
              adq_q     <= hi_done_q ? rd_word_c[7:0] : rd_word_c[15:8];
              hi_done_q <= ~hi_done_q;
              if (hi_done_q) addr_q <= next_addr(addr_q, reg_q, lin_q);
            end else if (!adq_oe_q) begin
              // One-clock preamble: take the bus with RWDS low before the first byte.
              adq_oe_q  <= 1'b1;
              rwds_oe_q <= 1'b1;
              adq_q     <= '0;
            end
          end
          DONE:    state_q <= DONE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hyperbus_target.sv
// Directed bench for hyperbus_target: drives the initiator side of hyperbus_if with
// hand-written transactions and checks data, latency, strobe toggles, aborts and reset.
module tb_hyperbus_target;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyperbus_if bus();

  hyperbus_target #(
    .AW(10), .LATENCY(6), .WRAP_LEN(16), .ID0(16'h0C81)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef HBT_BYTE_MASK_EN
  localparam logic [15:0] MASK_EXP = 16'hAB34;
`else
  localparam logic [15:0] MASK_EXP = 16'hABCD;
`endif

  int          checks = 0;
  int          errors = 0;
  int          toggles;
  logic [15:0] rd_buf [8];
  logic [15:0] wr_buf [8];
  logic        wr_mh  [8];
  logic        wr_ml  [8];

  function automatic logic [47:0] make_ca(input logic rd, input logic rg, input logic lin,
                                          input logic [31:0] wa);
    return {rd, rg, lin, wa[31:3], 13'd0, wa[2:0]};
  endfunction

  // One bus edge: data/mask settle two clocks before ram_clk toggles.
  task automatic bus_edge(input logic [7:0] d, input logic m);
    @(posedge clk); #1;
    bus.ram_adq_m  = d;
    bus.ram_rwds_m = m;
    repeat (2) @(posedge clk); #1;
    bus.ram_clk = ~bus.ram_clk;
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic cs_low();
    @(posedge clk); #1;
    bus.ram_cs = 1'b0;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic cs_high();
    @(posedge clk); #1;
    bus.ram_cs = 1'b1;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic send_ca(input logic [47:0] ca);
    for (int i = 0; i < 6; i++) bus_edge(ca[47-8*i -: 8], 1'b0);
  endtask

  task automatic read_data(input int n);
    logic       prev;
    logic [7:0] hi;
    toggles = 0;
    for (int i = 0; i < n; i++) begin
      prev = bus.ram_rwds;
      bus_edge(8'h00, 1'b0);
      if (bus.ram_rwds !== prev) toggles++;
      hi   = bus.ram_adq;
      prev = bus.ram_rwds;
      bus_edge(8'h00, 1'b0);
      if (bus.ram_rwds !== prev) toggles++;
      rd_buf[i] = {hi, bus.ram_adq};
    end
  endtask

  task automatic read_words(input logic [47:0] ca, input int n);
    cs_low();
    send_ca(ca);
    repeat (24) bus_edge(8'h00, 1'b0);
    read_data(n);
    cs_high();
  endtask

  task automatic write_words(input logic [47:0] ca, input int lat, input int n);
    cs_low();
    send_ca(ca);
    repeat (lat) bus_edge(8'h00, 1'b0);
    for (int i = 0; i < n; i++) begin
      bus_edge(wr_buf[i][15:8], wr_mh[i]);
      bus_edge(wr_buf[i][7:0], wr_ml[i]);
    end
    cs_high();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ram_cs = 1'b1;
    bus.ram_clk = 1'b0;
    bus.ram_adq_m = 8'h00;
    bus.ram_rwds_m = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.err); end
    checks++; if (bus.ram_adq_s_oe !== 1'b0) begin errors++; $display("FAIL rst_adq_oe: got %b expected 0", bus.ram_adq_s_oe); end
    checks++; if (bus.ram_rwds_s_oe !== 1'b0) begin errors++; $display("FAIL rst_rwds_oe: got %b expected 0", bus.ram_rwds_s_oe); end
  endtask

  task automatic test_linear();
    logic [15:0] exp [4];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin wr_buf[i] = exp[i]; wr_mh[i] = 1'b0; wr_ml[i] = 1'b0; end
    write_words(make_ca(1'b0, 1'b0, 1'b1, 32'h10), 24, 4);
    cs_low();
    checks++; if (bus.busy !== 1'b1 || bus.ram_rwds_s_oe !== 1'b1 || bus.ram_rwds !== 1'b1) begin
      errors++; $display("FAIL cmd_entry: got busy=%b rwds_oe=%b rwds=%b expected 1 1 1",
                         bus.busy, bus.ram_rwds_s_oe, bus.ram_rwds); end
    send_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h10));
    repeat (23) bus_edge(8'h00, 1'b0);
    checks++; if (bus.ram_adq_s_oe !== 1'b0 || bus.ram_rwds !== 1'b1) begin
      errors++; $display("FAIL lat_hold: got adq_oe=%b rwds=%b expected 0 1", bus.ram_adq_s_oe, bus.ram_rwds); end
    bus_edge(8'h00, 1'b0);
    checks++; if (bus.ram_adq_s_oe !== 1'b1 || bus.ram_rwds_s_oe !== 1'b1 || bus.ram_rwds !== 1'b0) begin
      errors++; $display("FAIL preamble: got adq_oe=%b rwds_oe=%b rwds=%b expected 1 1 0",
                         bus.ram_adq_s_oe, bus.ram_rwds_s_oe, bus.ram_rwds); end
    read_data(4);
    cs_high();
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_buf[i] !== exp[i]) begin errors++; $display("FAIL lin_rd%0d: got %h expected %h", i, rd_buf[i], exp[i]); end
    end
    checks++; if (toggles !== 8) begin errors++; $display("FAIL lin_toggles: got %0d expected 8", toggles); end
    checks++; if (bus.busy !== 1'b0 || bus.ram_adq_s_oe !== 1'b0 || bus.ram_rwds_s_oe !== 1'b0) begin
      errors++; $display("FAIL lin_release: got busy=%b adq_oe=%b rwds_oe=%b expected 0 0 0",
                         bus.busy, bus.ram_adq_s_oe, bus.ram_rwds_s_oe); end
  endtask

  task automatic test_wrapped();
    logic [15:0] exp [4];
    wr_buf[0] = 16'hAAAA; wr_buf[1] = 16'hBBBB;
    for (int i = 0; i < 2; i++) begin wr_mh[i] = 1'b0; wr_ml[i] = 1'b0; end
    write_words(make_ca(1'b0, 1'b0, 1'b1, 32'h1E), 24, 2);
    exp[0] = 16'hAAAA; exp[1] = 16'hBBBB; exp[2] = 16'h1111; exp[3] = 16'h2222;
    read_words(make_ca(1'b1, 1'b0, 1'b0, 32'h1E), 4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_buf[i] !== exp[i]) begin errors++; $display("FAIL wrap_rd%0d: got %h expected %h", i, rd_buf[i], exp[i]); end
    end
  endtask

  task automatic test_register();
    read_words(make_ca(1'b1, 1'b1, 1'b1, 32'h0), 1);
    checks++; if (rd_buf[0] !== 16'h0C81) begin errors++; $display("FAIL reg_id0: got %h expected 0c81", rd_buf[0]); end
    read_words(make_ca(1'b1, 1'b1, 1'b1, 32'h1), 1);
    checks++; if (rd_buf[0] !== 16'h8F1F) begin errors++; $display("FAIL reg_cr0_rst: got %h expected 8f1f", rd_buf[0]); end
    wr_buf[0] = 16'h8F17; wr_mh[0] = 1'b0; wr_ml[0] = 1'b0;
    write_words(make_ca(1'b0, 1'b1, 1'b1, 32'h1), 0, 1);
    read_words(make_ca(1'b1, 1'b1, 1'b1, 32'h1), 2);
    checks++; if (rd_buf[0] !== 16'h8F17) begin errors++; $display("FAIL reg_cr0_wr: got %h expected 8f17", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 16'h8F17) begin errors++; $display("FAIL reg_no_inc: got %h expected 8f17", rd_buf[1]); end
    read_words(make_ca(1'b1, 1'b1, 1'b1, 32'h0), 1);
    checks++; if (rd_buf[0] !== 16'h0C81) begin errors++; $display("FAIL reg_id0_ro: got %h expected 0c81", rd_buf[0]); end
  endtask

  task automatic test_mask();
    wr_buf[0] = 16'h1234; wr_mh[0] = 1'b0; wr_ml[0] = 1'b0;
    write_words(make_ca(1'b0, 1'b0, 1'b1, 32'h40), 24, 1);
    wr_buf[0] = 16'hABCD; wr_mh[0] = 1'b0; wr_ml[0] = 1'b1;
    write_words(make_ca(1'b0, 1'b0, 1'b1, 32'h40), 24, 1);
    read_words(make_ca(1'b1, 1'b0, 1'b1, 32'h40), 1);
    checks++; if (rd_buf[0] !== MASK_EXP) begin errors++; $display("FAIL mask_rd: got %h expected %h", rd_buf[0], MASK_EXP); end
  endtask

  task automatic test_cs_abort();
    logic [47:0] ca;
    int          err_seen;
    ca = make_ca(1'b1, 1'b0, 1'b1, 32'h10);
    cs_low();
    for (int i = 0; i < 3; i++) bus_edge(ca[47-8*i -: 8], 1'b0);
    @(posedge clk); #1;
    bus.ram_cs = 1'b1;
    err_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.err === 1'b1) err_seen++;
      if (i == 2) begin
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b expected 1", bus.err); end
        checks++; if (bus.busy !== 1'b0 || bus.ram_adq_s_oe !== 1'b0 || bus.ram_rwds_s_oe !== 1'b0) begin
          errors++; $display("FAIL abort_release: got busy=%b adq_oe=%b rwds_oe=%b expected 0 0 0",
                             bus.busy, bus.ram_adq_s_oe, bus.ram_rwds_s_oe); end
      end
    end
    checks++; if (err_seen !== 1) begin errors++; $display("FAIL abort_err_count: got %0d expected 1", err_seen); end
    read_words(make_ca(1'b1, 1'b0, 1'b1, 32'h10), 2);
    checks++; if (rd_buf[0] !== 16'h1111 || rd_buf[1] !== 16'h2222) begin
      errors++; $display("FAIL abort_recover: got %h %h expected 1111 2222", rd_buf[0], rd_buf[1]); end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] exp [4];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
    cs_low();
    send_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h10));
    repeat (24) bus_edge(8'h00, 1'b0);
    repeat (3) bus_edge(8'h00, 1'b0);
    checks++; if (bus.ram_adq_s_oe !== 1'b1) begin errors++; $display("FAIL mid_read_drive: got %b expected 1", bus.ram_adq_s_oe); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.ram_adq_s_oe !== 1'b0 || bus.ram_rwds_s_oe !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_async: got adq_oe=%b rwds_oe=%b busy=%b expected 0 0 0",
                         bus.ram_adq_s_oe, bus.ram_rwds_s_oe, bus.busy); end
    bus.ram_cs = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    read_words(make_ca(1'b1, 1'b0, 1'b1, 32'h10), 4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_buf[i] !== exp[i]) begin errors++; $display("FAIL post_rst_rd%0d: got %h expected %h", i, rd_buf[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_wrapped();
    test_register();
    test_mask();
    test_cs_abort();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
